// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake and a two-entry skid buffer.
// Define EX_MEM_SKID_EN for the registered-ready two-entry mode; otherwise a single entry with combinational ready.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              zero_flag,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              branch,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic              out_zero_flag,
  output logic [DATA_W-1:0] out_store_data,
  output logic [DATA_W-1:0] out_branch_target,
  output logic [REG_W-1:0]  out_dest_reg,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic              out_branch,
  output logic              branch_taken
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic              zero_flag;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] branch_target;
    logic [REG_W-1:0]  dest_reg;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic              branch;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  typedef enum logic [1:0] {M_HOLD = 2'd0, M_IN = 2'd1, M_SKID = 2'd2, M_CLR = 2'd3} main_sel_t;
  typedef enum logic [1:0] {S_HOLD = 2'd0, S_IN = 2'd1, S_CLR = 2'd2} skid_sel_t;

  state_t    state;
  state_t    state_nxt;
  main_sel_t main_sel;
  skid_sel_t skid_sel;
  entry_t    main_q;
  entry_t    skid_q;
  entry_t    in_entry;
  logic      accept;
  logic      consume;

  assign in_entry = '{alu_out:       alu_out,
                      zero_flag:     zero_flag,
                      store_data:    store_data,
                      branch_target: branch_target,
                      dest_reg:      dest_reg,
                      mem_read:      mem_read,
                      mem_write:     mem_write,
                      reg_write:     reg_write,
                      mem_to_reg:    mem_to_reg,
                      branch:        branch};

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // Occupancy register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy next state; flush overrides any transfer
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_nxt = ONE;
        ONE: begin
          if (accept && !consume)      state_nxt = FULL;
          else if (!accept && consume) state_nxt = EMPTY;
        end
        FULL:    if (consume) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Entry load selects; vacated entries are cleared so invalid heads show zero control bits
  always_comb begin
    main_sel = M_HOLD;
    skid_sel = S_HOLD;
    if (flush) begin
      main_sel = M_CLR;
      skid_sel = S_CLR;
    end else begin
      case (state)
        EMPTY: if (accept) main_sel = M_IN;
        ONE: begin
          if (accept && consume) main_sel = M_IN;
          else if (accept)       skid_sel = S_IN;
          else if (consume)      main_sel = M_CLR;
        end
        FULL: begin
          if (consume) begin
            main_sel = M_SKID;
            skid_sel = S_CLR;
          end
        end
        default: begin
          main_sel = M_CLR;
          skid_sel = S_CLR;
        end
      endcase
    end
  end

  // Entry storage and head valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_nxt != EMPTY);
      case (main_sel)
        M_IN:    main_q <= in_entry;
        M_SKID:  main_q <= skid_q;
        M_CLR:   main_q <= '0;
        default: main_q <= main_q;
      endcase
      case (skid_sel)
        S_IN:    skid_q <= in_entry;
        S_CLR:   skid_q <= '0;
        default: skid_q <= skid_q;
      endcase
    end
  end

`ifdef EX_MEM_SKID_EN
  // Ready is registered: high whenever the skid slot will be free next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_nxt != FULL);
    end
  end
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign out_alu_out       = main_q.alu_out;
  assign out_zero_flag     = main_q.zero_flag;
  assign out_store_data    = main_q.store_data;
  assign out_branch_target = main_q.branch_target;
  assign out_dest_reg      = main_q.dest_reg;
  assign out_mem_read      = main_q.mem_read;
  assign out_mem_write     = main_q.mem_write;
  assign out_reg_write     = main_q.reg_write;
  assign out_mem_to_reg    = main_q.mem_to_reg;
  assign out_branch        = main_q.branch;
  assign branch_taken      = out_valid && main_q.branch && main_q.zero_flag;

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: DATA_W, 32, width of ALU result, store data and branch target.
REQ-002 Parameter: REG_W, 5, width of destination register index.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  1  execute stage presents a valid result this cycle.
REQ-006 Port: in_ready  output  1  stage accepts input this cycle; transfer occurs when in_valid && in_ready.
REQ-007 Port: alu_out  input  DATA_W  ALU result, used as memory address or writeback value.
REQ-008 Port: zero_flag  input  1  ALU equality flag (operands equal).
REQ-009 Port: store_data, branch_target  input  DATA_W each  rt value for stores; computed branch address.
REQ-010 Port: dest_reg  input  REG_W  writeback register index.
REQ-011 Port: mem_read, mem_write, reg_write, mem_to_reg, branch  input  1 each  control bits from decode.
REQ-012 Port: flush  input  1  discard all held entries.
REQ-013 Port: out_valid  output  1  head entry is valid toward the memory stage.
REQ-014 Port: out_ready  input  1  memory stage consumes head when out_valid && out_ready.
REQ-015 Port: out_* (alu_out, store_data, branch_target, dest_reg, the five control bits)  output  same widths  head entry fields, driven from registers.
REQ-016 Port: branch_taken  output  1  = out_valid && out_branch && out_zero_flag, combinational from head registers.

Function
REQ-017 Storage is two entries, main (head) and skid; occupancy states EMPTY (0), ONE (1), FULL (2).
REQ-018 in_ready is registered and equals 1 exactly when the skid entry is empty (state EMPTY or ONE).
REQ-019 EMPTY: accept -> input loads main, go ONE; no accept -> stay EMPTY.
REQ-020 ONE: accept and consume -> input loads main, stay ONE; accept only -> input loads skid, go FULL; consume only -> go EMPTY; neither -> hold.
REQ-021 FULL: consume -> skid moves to main, skid cleared, go ONE; no consume -> hold all; no input accepted (in_ready 0).
REQ-022 Latency: an accepted input appears at the outputs on the next edge when the stage was EMPTY or ONE with simultaneous consume; order is strictly FIFO.
REQ-023 Head fields do not change while out_valid && !out_ready.
REQ-024 flush is synchronous and highest priority: next edge state is EMPTY, out_valid 0, in_ready 1; a same-cycle input transfer is discarded.
REQ-025 Invalid entries drive all out_* control bits as 0; data fields are don't-care but are not X after reset.
REQ-026 No arithmetic is performed; all fields pass through unmodified and bit-exact.

Reset
REQ-027 reset asserted asynchronously forces state EMPTY, out_valid 0, in_ready 1, all data and control registers 0, branch_taken 0.
REQ-028 Reset asserted mid-transfer discards both entries; the first rising edge after deassertion may accept input.

Configuration
REQ-029 Macro EX_MEM_SKID_EN defined: two-entry behaviour per REQ-017 to REQ-021.
REQ-030 Macro EX_MEM_SKID_EN undefined: single entry only; in_ready = !out_valid || out_ready (combinational); accept loads main; flush, reset, branch_taken unchanged.

Verification
REQ-031 Reset then in_valid=1, alu_out=0x0000_0010, reg_write=1, out_ready=1 -> next edge out_valid=1, out_alu_out=0x10, out_reg_write=1.
REQ-032 out_ready=0, send A=0x1, B=0x2 on consecutive cycles -> in_ready=0 after B; raise out_ready -> out_alu_out 0x1 then 0x2, no loss or duplication.
REQ-033 Head with branch=1, zero_flag=1, branch_target=0x0040_0020 -> branch_taken=1, out_branch_target=0x0040_0020; zero_flag=0 -> branch_taken=0.
REQ-034 FULL state, assert flush with in_valid=1 -> next edge out_valid=0, in_ready=1, flushed input not emitted.
REQ-035 Assert reset asynchronously between edges while FULL -> out_valid falls immediately, all outputs 0.
REQ-036 Random in_valid/out_ready for 10000 cycles, both macro settings -> output sequence equals input sequence.
